load_unit: RTL and testbench
============================

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter: XLEN, default `XLEN from core/params.svh (64), register and address width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 req_valid  input  1  load request from execute stage.
REQ-005 req_ready  output  1  unit idle and able to accept a request.
REQ-006 req_addr  input  XLEN  effective byte address (base + imm).
REQ-007 req_funct3  input  3  RISC-V load funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
REQ-008 req_rd  input  5  destination register index.
REQ-009 araddr/arvalid/arready/arprot  AXI4-lite AR channel, 32-bit address; arprot fixed 3'b000.
REQ-010 rdata/rresp/rvalid/rready  AXI4-lite R channel, 32-bit data.
REQ-011 resp_valid  output  1  one-cycle pulse: load complete.
REQ-012 resp_data  output  XLEN  extended load result.
REQ-013 resp_rd  output  5  rd of completed load.
REQ-014 resp_fault  output  1  bus error or illegal funct3; qualified by resp_valid.

Function
REQ-015 Request accepted on a cycle with req_valid && req_ready; req_ready = 1 only in IDLE.
REQ-016 Access size: 1/2/4/8 bytes from funct3[1:0]; sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
REQ-017 Word count N = ceil((addr[1:0] + size)/4), range 1..3; misaligned accesses are fully supported by reading N consecutive aligned words.
REQ-018 Word k address = {addr[31:2], 2'b00} + 4k; wrap-around at 2^32 is modular, no fault.
REQ-019 FSM states: IDLE -> ADDR (arvalid=1 until arready) -> DATA (rready=1 until rvalid) -> ADDR if words remain, else DONE -> IDLE.
REQ-020 One AR outstanding at a time; araddr and arvalid stable while arvalid && !arready.
REQ-021 Beats gathered little-endian into a 96-bit buffer; result = buffer >> (8*addr[1:0]), truncated to size, then extended to XLEN.
REQ-022 DONE asserts resp_valid for exactly one cycle; resp_data, resp_rd, resp_fault held until next DONE.
REQ-023 Minimum latency with arready and rvalid immediate: 2N+1 cycles from acceptance to resp_valid.
REQ-024 rresp != 2'b00 on any beat sets a sticky fault; remaining beats still issued and drained; resp_data = 0 when fault.
REQ-025 funct3 = 3'b111: no bus traffic; DONE next cycle with resp_fault=1, resp_data=0.
REQ-026 rready asserted only in DATA; rvalid outside DATA is ignored.

Reset
REQ-027 While rst=0: state IDLE, arvalid=0, rready=0, resp_valid=0, resp_fault=0, resp_data=0, resp_rd=0, araddr=0, buffer cleared.
REQ-028 Reset mid-transaction abandons it immediately with no response; req_ready=1 on first edge after release.

Structure
REQ-029 Load-size/extension enum (funct3 decode) and FSM state typedef in a shared core package, reused by store unit.
REQ-030 Sub-module load_extend: combinational shift/truncate/extend of the 96-bit buffer; FSM and AXI handshakes in load_unit.

Verification
REQ-031 Memory 0x2C=0x8A8FC3C7, 0x30=0x017F423C, 0x34=0x66778899; LD 0x30 -> resp_data 0x66778899_017F423C, 2 beats, fault 0.
REQ-032 LB 0x2F -> 0xFFFFFFFF_FFFFFF8A; LBU 0x2F -> 0x8A; LHU 0x2C -> 0xC3C7; LW 0x2C -> 0xFFFFFFFF_8A8FC3C7.
REQ-033 Misaligned LW 0x2E -> 0xFFFFFFFF_8A8F... no: bytes 8F,8A,3C,42 -> 0x00000000_423C8A8F; ARs 0x2C then 0x30.
REQ-034 LD 0x2D -> 3 beats (0x2C, 0x30, 0x34), resp_data 0x99017F42_3C8A8FC3; arready/rvalid delayed 3 cycles -> same result.
REQ-035 SLVERR on beat 1 of 2 -> beat 2 still read, resp_valid with resp_fault=1, resp_data=0; funct3=111 -> fault, zero AR.
REQ-036 rst=0 while arvalid=1 -> arvalid drops asynchronously, no resp_valid; next LW 0x30 -> 0x017F423C.

Source files
------------

// File: rtl/load_unit_pkg.sv
// Shared load/store definitions: funct3 decode, access-size enum and the memory FSM state type.
// The store unit imports the same types.
package load_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } ld_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } lsu_state_e;

  typedef struct packed {
    ld_size_e size;
    logic     is_unsigned;
    logic     illegal;
  } ld_decode_t;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  function automatic ld_decode_t decode_funct3(input logic [2:0] f3);
    ld_decode_t d;
    d.size        = ld_size_e'(f3[1:0]);
    d.is_unsigned = f3[2];
    d.illegal     = (f3 == 3'b111);
    return d;
  endfunction

  // Aligned 32-bit words touched by an access starting at byte offset off.
  function automatic logic [1:0] word_count(input logic [1:0] off, input ld_size_e size);
    logic [3:0] span;
    span = {2'b00, off} + (4'd1 << size);
    return 2'((span + 4'd3) >> 2);
  endfunction

endpackage

// File: rtl/load_unit_extend.sv
// Combinational byte alignment of the gathered beats: shift by the byte offset,
// truncate to the access size, then sign- or zero-extend to XLEN.
module load_extend
  import load_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [95:0]     beat_buf,
  input  logic [1:0]      byte_off,
  input  ld_size_e        size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);

  logic [63:0] shifted;
  logic [63:0] mask;
  logic [63:0] val;
  logic        sign;

  always_comb begin
    shifted = 64'(beat_buf >> {byte_off, 3'b000});
    mask    = '1;
    sign    = 1'b0;
    unique case (size)
      SZ_BYTE:  begin mask = 64'h0000_0000_0000_00FF; sign = shifted[7];  end
      SZ_HALF:  begin mask = 64'h0000_0000_0000_FFFF; sign = shifted[15]; end
      SZ_WORD:  begin mask = 64'h0000_0000_FFFF_FFFF; sign = shifted[31]; end
      default:  begin mask = '1;                      sign = shifted[63]; end
    endcase
    if (is_unsigned) sign = 1'b0;
    val  = (shifted & mask) | ({64{sign}} & ~mask);
    data = XLEN'($signed(val));
  end

endmodule

// File: rtl/load_unit.sv
// RISC-V load unit: issues one AXI4-lite read per aligned word touched by the access
// (1..3 words, misaligned supported) and returns the extended result as a one-cycle pulse.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  input  logic [4:0]      req_rd,
  output logic [31:0]     araddr,
  output logic            arvalid,
  input  logic            arready,
  output logic [2:0]      arprot,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            resp_fault
);

  lsu_state_e      state_q, state_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [1:0]      beat_q, beat_d;
  logic [1:0]      nwords_q, nwords_d;
  logic [1:0]      off_q, off_d;
  ld_size_e        size_q, size_d;
  logic            uns_q, uns_d;
  logic [4:0]      rd_q, rd_d;
  logic            fault_q, fault_d;
  logic [95:0]     buf_q, buf_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic [4:0]      resp_rd_q, resp_rd_d;
  logic            resp_fault_q, resp_fault_d;

  logic [XLEN-1:0] ext_data;
  ld_decode_t      req_dec;
  logic            beat_fire;
  logic            beat_err;
  logic            last_beat;

  assign req_dec   = decode_funct3(req_funct3);
  assign beat_fire = (state_q == ST_DATA) && rvalid;
  assign beat_err  = (rresp != AXI_RESP_OKAY);
  assign last_beat = (beat_q == nwords_q - 2'd1);

  // Beat merge kept apart from the FSM so the extender sees the final beat in the same cycle.
  always_comb begin
    buf_d = buf_q;
    if ((state_q == ST_IDLE) && req_valid) begin
      buf_d = '0;
    end else if (beat_fire) begin
      case (beat_q)
        2'd0:    buf_d[31:0]  = rdata;
        2'd1:    buf_d[63:32] = rdata;
        default: buf_d[95:64] = rdata;
      endcase
    end
  end

  load_extend #(.XLEN(XLEN)) u_extend (
    .beat_buf    (buf_d),
    .byte_off    (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (ext_data)
  );

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    beat_d       = beat_q;
    nwords_d     = nwords_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    rd_d         = rd_q;
    fault_d      = fault_q;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    resp_fault_d = resp_fault_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rd_d    = req_rd;
          off_d   = req_addr[1:0];
          size_d  = req_dec.size;
          uns_d   = req_dec.is_unsigned;
          beat_d  = 2'd0;
          fault_d = 1'b0;
          if (req_dec.illegal) begin
            state_d      = ST_DONE;
            resp_rd_d    = req_rd;
            resp_fault_d = 1'b1;
            resp_data_d  = '0;
          end else begin
            nwords_d = word_count(req_addr[1:0], req_dec.size);
            araddr_d = {req_addr[31:2], 2'b00};
            state_d  = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (rvalid) begin
          // Errors are sticky; remaining beats are still fetched to keep the bus in step.
          fault_d = fault_q | beat_err;
          if (last_beat) begin
            state_d      = ST_DONE;
            resp_rd_d    = rd_q;
            resp_fault_d = fault_d;
            resp_data_d  = fault_d ? '0 : ext_data;
          end else begin
            beat_d   = beat_q + 2'd1;
            araddr_d = araddr_q + 32'd4;
            state_d  = ST_ADDR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      araddr_q     <= '0;
      beat_q       <= '0;
      nwords_q     <= '0;
      off_q        <= '0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      rd_q         <= '0;
      fault_q      <= 1'b0;
      buf_q        <= '0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      beat_q       <= beat_d;
      nwords_q     <= nwords_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      rd_q         <= rd_d;
      fault_q      <= fault_d;
      buf_q        <= buf_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign arvalid    = (state_q == ST_ADDR);
  assign rready     = (state_q == ST_DATA);
  assign resp_valid = (state_q == ST_DONE);
  assign araddr     = araddr_q;
  assign arprot     = AXI_PROT_DEFAULT;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign resp_fault = resp_fault_q;

  // The AXI address is 32 bits; upper effective-address bits do not reach the bus.
  generate
    if (XLEN > 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[XLEN-1:32];
    end
  endgenerate

endmodule

// File: tb/tb_load_unit.sv
// Load unit bench: byte-level memory model, AXI-lite slave with delays and error injection,
// directed examples followed by randomized loads.
module tb_load_unit;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [2:0]      req_funct3;
  logic [4:0]      req_rd;
  logic [31:0]     araddr;
  logic            arvalid;
  logic            arready;
  logic [2:0]      arprot;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic [4:0]      resp_rd;
  logic            resp_fault;

  int checks = 0;
  int errors = 0;
  string ctx = "init";

  int ar_dly = 0;
  int r_dly = 0;
  int err_beat = 9;
  int beat_no = 0;
  int stab_viol = 0;
  logic [31:0] ar_log[$];

  always #5 clk = ~clk;

  load_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_rd     (req_rd),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .arprot     (arprot),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .resp_fault (resp_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_002C: return 32'h8A8F_C3C7;
      32'h0000_0030: return 32'h017F_423C;
      32'h0000_0034: return 32'h6677_8899;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  // Reference: assemble bytes one at a time from the byte address, then extend.
  function automatic logic [63:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int nb;
    logic [63:0] v;
    nb = 1 << f3[1:0];
    v  = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_byte(a + 32'(i));
    if (!f3[2] && v[8*nb-1]) for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s [%s] observed=%0h expected=%0h", tag, ctx, obs, exp);
    end
  endtask

  // AXI4-lite slave: all activity at negedges; a handshake seen at one negedge fires on the next posedge.
  initial begin : slave
    bit ar_fire, r_fire, have_addr, ar_waiting;
    int ar_cnt, r_cnt;
    logic [31:0] lat_addr;
    ar_fire = 0; r_fire = 0; have_addr = 0; ar_waiting = 0;
    ar_cnt = 0; r_cnt = 0; lat_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (ar_fire) begin
        arready = 1'b0; have_addr = 1; r_cnt = r_dly; ar_cnt = 0;
        ar_log.push_back(lat_addr);
      end
      if (r_fire) begin
        rvalid = 1'b0; rresp = 2'b00; have_addr = 0; beat_no++;
      end
      if (!rst) begin
        arready = 1'b0; rvalid = 1'b0; have_addr = 0; ar_cnt = 0; ar_waiting = 0;
      end else begin
        if (ar_waiting && arvalid && araddr !== lat_addr) stab_viol++;
        if (arvalid && !arready && !have_addr) begin
          lat_addr = araddr;
          if (ar_cnt >= ar_dly) arready = 1'b1;
          else ar_cnt++;
        end
        if (have_addr && !rvalid) begin
          if (r_cnt <= 0) begin
            rvalid = 1'b1;
            rdata  = mem_word(lat_addr);
            rresp  = (beat_no == err_beat) ? 2'b10 : 2'b00;
          end else begin
            r_cnt--;
          end
        end
      end
      ar_waiting = arvalid && !arready;
      ar_fire    = arvalid && arready;
      r_fire     = rvalid && rready;
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3,
                         input int ad, input int rdl, input int eb);
    int nb, nw, k;
    bit got, illegal, exp_f;
    logic [4:0] rd;
    logic [63:0] exp_d;
    logic [31:0] wa;
    $sformat(ctx, "addr=%08h f3=%0d", a, f3);
    rd = 5'($urandom_range(1, 31));
    illegal = (f3 == 3'b111);
    nb = 1 << f3[1:0];
    nw = illegal ? 0 : (int'(a[1:0]) + nb + 3) / 4;
    exp_f = illegal || (eb < nw);
    exp_d = exp_f ? 64'h0 : ref_load(a, f3);
    ar_dly = ad; r_dly = rdl; err_beat = eb; beat_no = 0;
    ar_log.delete();
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    chk("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_addr = {32'($urandom), a}; req_funct3 = f3; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_busy", 64'(req_ready), 64'(0));
    k = 1; got = 0;
    while (k < 300) begin
      if (resp_valid) begin got = 1; break; end
      @(negedge clk);
      k++;
    end
    chk("resp_in_time", 64'(got), 64'(1));
    if (got) begin
      if (ad == 0 && rdl == 0) chk("latency", 64'(k), 64'(illegal ? 1 : 2*nw + 1));
      chk("resp_data", resp_data, exp_d);
      chk("resp_rd", 64'(resp_rd), 64'(rd));
      chk("resp_fault", 64'(resp_fault), 64'(exp_f));
      chk("ar_count", 64'(ar_log.size()), 64'(nw));
      for (int i = 0; i < nw && i < ar_log.size(); i++) begin
        wa = {a[31:2], 2'b00} + 32'(4*i);
        chk("ar_addr", 64'(ar_log[i]), 64'(wa));
      end
      @(negedge clk);
      chk("resp_pulse", 64'(resp_valid), 64'(0));
      chk("resp_hold", resp_data, exp_d);
    end
    $display("load addr=%08h f3=%0d ad=%0d rd=%0d eb=%0d -> data=%016h fault=%0d cycles=%0d",
             a, f3, ad, rdl, eb, resp_data, resp_fault, k);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] a;
    logic [2:0] f3;
    int eb;
    bit seen;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
    repeat (3) @(negedge clk);
    ctx = "reset";
    chk("rst_arvalid", 64'(arvalid), 64'(0));
    chk("rst_rready", 64'(rready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data", resp_data, 64'(0));
    chk("rst_resp_fault", 64'(resp_fault), 64'(0));
    chk("rst_araddr", 64'(araddr), 64'(0));
    chk("arprot", 64'(arprot), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'(1));

    do_load(32'h30, 3'b011, 0, 0, 9);
    do_load(32'h2F, 3'b000, 0, 0, 9);
    do_load(32'h2F, 3'b100, 0, 0, 9);
    do_load(32'h2C, 3'b101, 0, 0, 9);
    do_load(32'h2C, 3'b010, 0, 0, 9);
    do_load(32'h2E, 3'b010, 0, 0, 9);
    do_load(32'h2D, 3'b011, 0, 0, 9);
    do_load(32'h2D, 3'b011, 3, 3, 9);
    do_load(32'h30, 3'b011, 0, 0, 0);
    do_load(32'h30, 3'b111, 0, 0, 9);
    do_load(32'hFFFF_FFFD, 3'b011, 0, 0, 9);
    do_load(32'h2B, 3'b110, 1, 0, 2);

    // Reset while an address phase is pending.
    ctx = "mid_reset";
    ar_dly = 6; r_dly = 0; err_beat = 9; beat_no = 0;
    req_valid = 1'b1; req_addr = 64'h30; req_funct3 = 3'b010; req_rd = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("arvalid_before_rst", 64'(arvalid), 64'(1));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arvalid_async_drop", 64'(arvalid), 64'(0));
    chk("araddr_cleared", 64'(araddr), 64'(0));
    chk("resp_data_cleared", resp_data, 64'(0));
    seen = 0;
    repeat (3) begin @(negedge clk); if (resp_valid) seen = 1; end
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(req_ready), 64'(1));
    repeat (4) begin if (resp_valid) seen = 1; @(negedge clk); end
    chk("no_resp_after_abort", 64'(seen), 64'(0));
    do_load(32'h30, 3'b010, 0, 0, 9);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else a = 32'h100 + 32'($urandom_range(0, 255));
      f3 = 3'($urandom_range(0, 7));
      eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : 9;
      do_load(a, f3, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), eb);
    end

    ctx = "end";
    chk("araddr_stable", 64'(stab_viol), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
